// File: rtl/mempool_tile_resp_router_pkg.sv
// mempool_pkg: tile-level sizes, index types and the default TCDM response payload.
package mempool_pkg;
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int unsigned NumCoresPerTile = 4;
  localparam int unsigned NumRemoteReqPortsPerTile = 4;
  localparam int unsigned MaxRemoteOutstanding = 8;
  typedef logic [idx_width(NumRemoteReqPortsPerTile)-1:0] remote_ports_index_t;
  typedef logic [idx_width(NumCoresPerTile)-1:0] tile_core_id_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  meta_id;
  } tcdm_slave_resp_t;
endpackage

// File: rtl/mempool_tile_resp_router_lane.sv
// mempool_tile_resp_lane: per-core outstanding counter, port selection and registered response stage.
// RESP_PORT_ORDER_EN: deliver in issue order via a per-core target-port FIFO instead of round-robin.
module mempool_tile_resp_lane
  import mempool_pkg::*;
#(
  parameter int unsigned NumPorts = NumRemoteReqPortsPerTile,
  parameter int unsigned MaxOutstanding = MaxRemoteOutstanding,
  parameter type resp_t = tcdm_slave_resp_t
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                req_hsk_i,
  input  logic [idx_width(NumPorts)-1:0]      req_tgt_sel_i,
  input  logic [NumPorts-1:0]                 elig_i,
  input  resp_t [NumPorts-1:0]                resp_i,
  output logic [NumPorts-1:0]                 gnt_o,
  output logic                                resp_valid_o,
  input  logic                                resp_ready_i,
  output resp_t                               resp_o,
  output logic                                full_o,
  output logic                                err_o
);
  localparam int unsigned PortW = idx_width(NumPorts);
  localparam int unsigned CntW = idx_width(MaxOutstanding) + 1;
  localparam logic [CntW-1:0] Max = CntW'(MaxOutstanding);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PortW-1:0] ptr_q, ptr_d, rr_idx, sel_idx, k;
  logic valid_q, valid_d, full_q, full_d, err_q, err_d;
  logic rr_any, sel_any, take, deliver, full_now;
  resp_t data_q, data_d;
  always_comb begin
    rr_any = 1'b0;
    rr_idx = '0;
    k = '0;
    for (int i = 0; i < NumPorts; i++) begin
      k = PortW'((int'(ptr_q) + i) % NumPorts);
      if (!rr_any && elig_i[k]) begin
        rr_any = 1'b1;
        rr_idx = k;
      end
    end
  end
`ifdef RESP_PORT_ORDER_EN
  logic fifo_empty, fifo_full;
  logic [PortW-1:0] head;
  fifo_v3 #(
    .FALL_THROUGH(1'b0),
    .DATA_WIDTH  (PortW),
    .DEPTH       (MaxOutstanding)
  ) i_order_fifo (
    .clk_i,
    .rst_ni,
    .flush_i   (1'b0),
    .testmode_i(1'b0),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .usage_o   (),
    .data_i    (req_tgt_sel_i),
    .push_i    (req_hsk_i & ~fifo_full),
    .data_o    (head),
    .pop_i     (take & ~fifo_empty)
  );
  // With nothing outstanding any response is a stray: take it so the error path discards it
  assign sel_any = fifo_empty ? rr_any : elig_i[head];
  assign sel_idx = fifo_empty ? rr_idx : head;
`else
  logic unused_tgt;
  assign unused_tgt = ^req_tgt_sel_i;
  assign sel_any = rr_any;
  assign sel_idx = rr_idx;
`endif
  always_comb begin
    take = sel_any & rst_ni & (~valid_q | resp_ready_i);
    deliver = take & (cnt_q != '0);
    gnt_o = '0;
    gnt_o[sel_idx] = take;
    full_now = cnt_q == Max;
    cnt_d = cnt_q + CntW'(req_hsk_i & (deliver | ~full_now)) - CntW'(deliver);
    ptr_d = take ? ((int'(sel_idx) == NumPorts - 1) ? '0 : sel_idx + 1'b1) : ptr_q;
    valid_d = deliver | (valid_q & ~resp_ready_i);
    data_d = deliver ? resp_i[sel_idx] : data_q;
    full_d = cnt_d == Max;
    err_d = err_q | (take & ~deliver) | (req_hsk_i & full_now);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ptr_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      full_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      valid_q <= valid_d;
      data_q <= data_d;
      full_q <= full_d;
      err_q <= err_d;
    end
  end
  assign resp_valid_o = valid_q;
  assign resp_o = data_q;
  assign full_o = full_q;
  assign err_o = err_q;
endmodule

// File: rtl/mempool_tile_resp_router.sv
// mempool_tile_resp_router: routes remote TCDM responses back to their cores through per-core lanes.
// RESP_PORT_ORDER_EN: lanes deliver responses in request issue order instead of round-robin.
module mempool_tile_resp_router
  import mempool_pkg::*;
#(
  parameter int unsigned NumCores = NumCoresPerTile,
  parameter int unsigned NumPorts = NumRemoteReqPortsPerTile,
  parameter int unsigned MaxOutstanding = MaxRemoteOutstanding,
  parameter type resp_t = tcdm_slave_resp_t
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic [NumCores-1:0]                          req_hsk_i,
  input  logic [NumCores-1:0][idx_width(NumPorts)-1:0] req_tgt_sel_i,
  input  logic [NumPorts-1:0]                          resp_valid_i,
  output logic [NumPorts-1:0]                          resp_ready_o,
  input  logic [NumPorts-1:0][idx_width(NumCores)-1:0] resp_core_i,
  input  resp_t [NumPorts-1:0]                         resp_i,
  output logic [NumCores-1:0]                          core_resp_valid_o,
  input  logic [NumCores-1:0]                          core_resp_ready_i,
  output resp_t [NumCores-1:0]                         core_resp_o,
  output logic [NumCores-1:0]                          outstanding_full_o,
  output logic                                         err_o
);
  localparam int unsigned CoreW = idx_width(NumCores);
  logic [NumCores-1:0][NumPorts-1:0] elig, gnt;
  logic [NumCores-1:0] lane_err;
  always_comb begin
    for (int c = 0; c < NumCores; c++)
      for (int p = 0; p < NumPorts; p++)
        elig[c][p] = resp_valid_i[p] & (resp_core_i[p] == CoreW'(c));
  end
  always_comb begin
    resp_ready_o = '0;
    for (int c = 0; c < NumCores; c++) resp_ready_o = resp_ready_o | gnt[c];
  end
  for (genvar c = 0; c < NumCores; c++) begin : g_lane
    mempool_tile_resp_lane #(
      .NumPorts      (NumPorts),
      .MaxOutstanding(MaxOutstanding),
      .resp_t        (resp_t)
    ) i_lane (
      .clk_i,
      .rst_ni,
      .req_hsk_i    (req_hsk_i[c]),
      .req_tgt_sel_i(req_tgt_sel_i[c]),
      .elig_i       (elig[c]),
      .resp_i       (resp_i),
      .gnt_o        (gnt[c]),
      .resp_valid_o (core_resp_valid_o[c]),
      .resp_ready_i (core_resp_ready_i[c]),
      .resp_o       (core_resp_o[c]),
      .full_o       (outstanding_full_o[c]),
      .err_o        (lane_err[c])
    );
  end
  assign err_o = |lane_err;
endmodule

// File: tb/tb_mempool_tile_resp_router.sv
// tb_mempool_tile_resp_router: directed checks of routing, back-pressure, counters, errors and reset.
module tb_mempool_tile_resp_router;
  import mempool_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_hsk_i;
  logic [3:0][1:0] req_tgt_sel_i;
  logic [3:0] resp_valid_i, resp_ready_o;
  logic [3:0][1:0] resp_core_i;
  tcdm_slave_resp_t [3:0] resp_i;
  logic [3:0] core_resp_valid_o, core_resp_ready_i, outstanding_full_o;
  tcdm_slave_resp_t [3:0] core_resp_o;
  logic err_o;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mempool_tile_resp_router dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_hsk_i(req_hsk_i),
    .req_tgt_sel_i(req_tgt_sel_i),
    .resp_valid_i(resp_valid_i),
    .resp_ready_o(resp_ready_o),
    .resp_core_i(resp_core_i),
    .resp_i(resp_i),
    .core_resp_valid_o(core_resp_valid_o),
    .core_resp_ready_i(core_resp_ready_i),
    .core_resp_o(core_resp_o),
    .outstanding_full_o(outstanding_full_o),
    .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hsk(input int c, input int p);
    req_hsk_i[c] = 1'b1;
    req_tgt_sel_i[c] = 2'(p);
    step();
    req_hsk_i[c] = 1'b0;
  endtask

  task automatic port(input int p, input int c, input logic [31:0] d);
    resp_valid_i[p] = 1'b1;
    resp_core_i[p] = 2'(c);
    resp_i[p] = '{data: d, meta_id: 4'(p)};
  endtask

  initial begin
    rst_n = 1'b0;
    req_hsk_i = '0;
    req_tgt_sel_i = '0;
    resp_valid_i = '0;
    resp_core_i = '0;
    resp_i = '0;
    core_resp_ready_i = 4'hF;
    step();
    step();
    chk("rst_ready", 64'(resp_ready_o), 64'h0);
    chk("rst_valid", 64'(core_resp_valid_o), 64'h0);
    chk("rst_data", 64'(|core_resp_o), 64'h0);
    chk("rst_full", 64'(outstanding_full_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    rst_n = 1'b1;
    step();

    // three responses for core 0 arriving together drain in port order 1,2,3
    hsk(0, 1);
    hsk(0, 2);
    hsk(0, 3);
    port(1, 0, 32'hA1);
    port(2, 0, 32'hA2);
    port(3, 0, 32'hA3);
    #1 chk("rr_ready1", 64'(resp_ready_o), 64'b0010);
    step();
    chk("rr_valid1", 64'(core_resp_valid_o[0]), 64'h1);
    chk("rr_data1", 64'(core_resp_o[0].data), 64'hA1);
    resp_valid_i[1] = 1'b0;
    #1 chk("rr_ready2", 64'(resp_ready_o), 64'b0100);
    step();
    chk("rr_data2", 64'(core_resp_o[0].data), 64'hA2);
    resp_valid_i[2] = 1'b0;
    #1 chk("rr_ready3", 64'(resp_ready_o), 64'b1000);
    step();
    chk("rr_data3", 64'(core_resp_o[0].data), 64'hA3);
    resp_valid_i[3] = 1'b0;
    step();
    chk("rr_drained", 64'(core_resp_valid_o[0]), 64'h0);
    chk("rr_err", 64'(err_o), 64'h0);

    // core 1 back-pressure holds the output and stalls port 2
    core_resp_ready_i[1] = 1'b0;
    hsk(1, 2);
    hsk(1, 2);
    port(2, 1, 32'hB1);
    #1 chk("bp_ready_empty", 64'(resp_ready_o), 64'b0100);
    step();
    chk("bp_valid", 64'(core_resp_valid_o[1]), 64'h1);
    chk("bp_data", 64'(core_resp_o[1].data), 64'hB1);
    port(2, 1, 32'hB2);
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_stall_ready", 64'(resp_ready_o), 64'h0);
      chk("bp_hold_valid", 64'(core_resp_valid_o[1]), 64'h1);
      chk("bp_hold_data", 64'(core_resp_o[1].data), 64'hB1);
      step();
    end
    core_resp_ready_i[1] = 1'b1;
    #1 chk("bp_drain_ready", 64'(resp_ready_o), 64'b0100);
    step();
    chk("bp_data2", 64'(core_resp_o[1].data), 64'hB2);
    chk("bp_valid2", 64'(core_resp_valid_o[1]), 64'h1);
    resp_valid_i = '0;
    step();
    chk("bp_drained", 64'(core_resp_valid_o[1]), 64'h0);

    // stray response for core 3 with nothing outstanding
    port(0, 3, 32'hD0);
    #1 chk("stray_ready", 64'(resp_ready_o), 64'b0001);
    step();
    resp_valid_i = '0;
    chk("stray_valid", 64'(core_resp_valid_o[3]), 64'h0);
    chk("stray_err", 64'(err_o), 64'h1);

    // asynchronous reset with responses pending
    core_resp_ready_i[1] = 1'b0;
    hsk(1, 1);
    hsk(1, 1);
    port(1, 1, 32'hC1);
    step();
    port(1, 1, 32'hC2);
    port(0, 0, 32'hC0);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_ready", 64'(resp_ready_o), 64'h0);
    chk("mid_rst_valid", 64'(core_resp_valid_o), 64'h0);
    chk("mid_rst_data", 64'(|core_resp_o), 64'h0);
    chk("mid_rst_err", 64'(err_o), 64'h0);
    resp_valid_i = '0;
    core_resp_ready_i = 4'hF;
    step();
    rst_n = 1'b1;
    step();
    hsk(1, 2);
    port(2, 1, 32'hF1);
    #1 chk("fresh_ready", 64'(resp_ready_o), 64'b0100);
    step();
    resp_valid_i = '0;
    chk("fresh_valid", 64'(core_resp_valid_o[1]), 64'h1);
    chk("fresh_data", 64'(core_resp_o[1].data), 64'hF1);
    chk("fresh_err", 64'(err_o), 64'h0);

    // core 2 reaches the outstanding limit and saturates
    repeat (7) hsk(2, 0);
    chk("full_at7", 64'(outstanding_full_o[2]), 64'h0);
    hsk(2, 0);
    chk("full_at8", 64'(outstanding_full_o[2]), 64'h1);
    chk("full_err0", 64'(err_o), 64'h0);
    hsk(2, 0);
    chk("ovf_err", 64'(err_o), 64'h1);
    chk("ovf_full", 64'(outstanding_full_o[2]), 64'h1);
    port(0, 2, 32'h60);
    step();
    resp_valid_i = '0;
    chk("ovf_deliver", 64'(core_resp_o[2].data), 64'h60);
    chk("ovf_unfull", 64'(outstanding_full_o[2]), 64'h0);

`ifdef RESP_PORT_ORDER_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    hsk(0, 3);
    hsk(0, 1);
    port(1, 0, 32'hE1);
    #1 chk("ord_stall", 64'(resp_ready_o), 64'h0);
    step();
    chk("ord_nodeliver", 64'(core_resp_valid_o[0]), 64'h0);
    port(3, 0, 32'hE3);
    #1 chk("ord_head_ready", 64'(resp_ready_o), 64'b1000);
    step();
    chk("ord_data3", 64'(core_resp_o[0].data), 64'hE3);
    resp_valid_i[3] = 1'b0;
    #1 chk("ord_next_ready", 64'(resp_ready_o), 64'b0010);
    step();
    resp_valid_i = '0;
    chk("ord_data1", 64'(core_resp_o[0].data), 64'hE1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
